// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state fetch/execute controller for the single-bus datapath
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            mem_rdy,
    input  logic [31:0]     ir_in,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            PCout,
    output logic            ZLowout,
    output logic            ZHighout,
    output logic            MDRout,
    output logic            HIout,
    output logic            LOout,
    output logic            Cout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            ZLowIn,
    output logic            ZHighIn,
    output logic            HIin,
    output logic            LOin,
    output logic            IncPC,
    output logic            Read,
    output logic [OPW-1:0]  operation,
    output logic            instr_done,
    output logic            halted
);
    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
    state_t state, nxt;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic is_r, is_i, is_md, is_un, is_halt;
    logic [4:0] alu_op;
    assign op      = ir_in[31:27];
    assign ra      = ir_in[26:23];
    assign rb      = ir_in[22:19];
    assign rc      = ir_in[18:15];
    assign is_r    = op <= 5'd11;
    assign is_i    = op >= 5'd12 && op <= 5'd14;
    assign is_md   = op == 5'd15 || op == 5'd16;
    assign is_un   = op == 5'd17 || op == 5'd18;
    assign is_halt = op == 5'd27;
    assign alu_op  = op == 5'd12 ? 5'd0 : op == 5'd13 ? 5'd2 : op == 5'd14 ? 5'd3 : op;
    always_ff @(posedge clk or posedge clr)
        if (clr) state <= RST;
        else     state <= nxt;
    always_comb begin
        nxt        = state;
        reg_in     = '0;
        reg_out    = '0;
        PCout      = 1'b0;
        ZLowout    = 1'b0;
        ZHighout   = 1'b0;
        MDRout     = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        Cout       = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowIn     = 1'b0;
        ZHighIn    = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        operation  = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            RST: nxt = T0;
            T0: if (run) begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                nxt   = T1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                nxt   = mem_rdy ? T2 : T1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                nxt    = T3;
            end
            T3: if (is_halt) nxt = HALT;
            else if (is_r || is_i || is_md || is_un) begin
                reg_out = NREG'(1) << rb;
                Yin     = 1'b1;
                nxt     = T4;
            end else begin
                instr_done = 1'b1;
                nxt        = T0;
            end
            T4: begin
                reg_out   = is_i ? '0 : NREG'(1) << (is_un ? rb : rc);
                Cout      = is_i;
                ZLowIn    = 1'b1;
                ZHighIn   = is_md;
                operation = OPW'(alu_op);
                nxt       = T5;
            end
            T5: begin
                ZLowout    = 1'b1;
                LOin       = is_md;
                reg_in     = (is_md || ra == 4'd0) ? '0 : NREG'(1) << ra;
                instr_done = !is_md;
                operation  = OPW'(alu_op);
                nxt        = is_md ? T6 : T0;
            end
            T6: begin
                ZHighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                operation  = OPW'(alu_op);
                nxt        = T0;
            end
            HALT: halted = 1'b1;
            default: nxt = RST;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction sequences checked cycle by cycle through a scoreboard queue
module tb_control_sequencer;
    logic        clk = 1'b0, clr = 1'b1, run = 1'b0, mem_rdy = 1'b1;
    logic [31:0] ir_in = '0;
    logic [15:0] reg_in, reg_out;
    logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
    logic        IncPC, Read, instr_done, halted;
    logic [4:0]  operation;
    control_sequencer #(.OPW(5), .NREG(16)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir_in(ir_in),
        .reg_in(reg_in), .reg_out(reg_out),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .operation(operation),
        .instr_done(instr_done), .halted(halted)
    );
    always #5 clk = ~clk;
    localparam logic [17:0] PCO = 18'h20000, ZLO = 18'h10000, ZHO = 18'h08000, MDRO = 18'h04000;
    localparam logic [17:0] CO = 18'h00800, MARI = 18'h00400, MDRI = 18'h00100, IRI = 18'h00080;
    localparam logic [17:0] YI = 18'h00040, ZLI = 18'h00020, ZHI = 18'h00010, HII = 18'h00008;
    localparam logic [17:0] LOI = 18'h00004, INC = 18'h00002, RD = 18'h00001;
    typedef struct {
        string       n;
        logic [56:0] v;
    } exp_t;
    exp_t q[$];
    int compared = 0, mismatched = 0;
    logic [56:0] obs;
    assign obs = {reg_in, reg_out, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout,
                  MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read,
                  operation, instr_done, halted};
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            compared++;
            if (obs !== e.v) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", e.n, obs, e.v);
            end
        end
    end
    function automatic logic [56:0] ev(input logic [15:0] ri, input logic [15:0] ro,
                                       input logic [17:0] s, input logic [4:0] opn,
                                       input logic d, input logic h);
        return {ri, ro, s, opn, d, h};
    endfunction
    function automatic logic [31:0] mkir(input logic [4:0] o, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        return {o, a, b, c, 15'b0};
    endfunction
    task automatic expect_v(input string n, input logic [56:0] v);
        exp_t e;
        e.n = n;
        e.v = v;
        q.push_back(e);
    endtask
    task automatic step(input string n, input logic c, input logic r, input logic m,
                        input logic [56:0] v);
        @(posedge clk);
        #1;
        clr = c;
        run = r;
        mem_rdy = m;
        expect_v(n, v);
    endtask
    task automatic fetch(input string n, input logic [31:0] ir, input int stalls);
        @(posedge clk);
        #1;
        clr = 1'b0;
        run = 1'b1;
        ir_in = ir;
        expect_v({n, "_t0"}, ev(0, 0, PCO | MARI | INC, 0, 0, 0));
        for (int i = 0; i < stalls; i++) step({n, "_t1_stall"}, 0, 0, 0, ev(0, 0, RD | MDRI, 0, 0, 0));
        step({n, "_t1"}, 0, 0, 1, ev(0, 0, RD | MDRI, 0, 0, 0));
        step({n, "_t2"}, 0, 0, 1, ev(0, 0, MDRO | IRI, 0, 0, 0));
    endtask
    task automatic exec(input string n, input logic [31:0] ir, input int stalls,
                        input logic [15:0] ro3, input logic [15:0] ro4, input logic [17:0] s4,
                        input logic [4:0] opn, input logic [15:0] ri5, input logic md);
        fetch(n, ir, stalls);
        step({n, "_t3"}, 0, 0, 1, ev(0, ro3, YI, 0, 0, 0));
        step({n, "_t4"}, 0, 0, 1, ev(0, ro4, s4, opn, 0, 0));
        if (md) begin
            step({n, "_t5"}, 0, 0, 1, ev(0, 0, ZLO | LOI, opn, 0, 0));
            step({n, "_t6"}, 0, 0, 1, ev(0, 0, ZHO | HII, opn, 1, 0));
        end else step({n, "_t5"}, 0, 0, 1, ev(ri5, 0, ZLO, opn, 1, 0));
    endtask
    initial begin
        step("reset", 1, 0, 1, '0);
        step("rst_state", 0, 0, 1, '0);
        exec("ror", 32'h42318000, 0, 16'h0040, 16'h0008, ZLI, 5'd8, 16'h0010, 0);
        exec("mul", mkir(15, 7, 3, 1), 0, 16'h0008, 16'h0002, ZLI | ZHI, 5'd15, 0, 1);
        exec("addi", mkir(12, 2, 5, 0), 3, 16'h0020, 16'h0000, CO | ZLI, 5'd0, 16'h0004, 0);
        exec("andi", mkir(13, 1, 1, 0), 0, 16'h0002, 16'h0000, CO | ZLI, 5'd2, 16'h0002, 0);
        exec("ori", mkir(14, 3, 4, 0), 1, 16'h0010, 16'h0000, CO | ZLI, 5'd3, 16'h0008, 0);
        exec("div", mkir(16, 0, 9, 10), 0, 16'h0200, 16'h0400, ZLI | ZHI, 5'd16, 0, 1);
        exec("neg", mkir(17, 1, 9, 0), 0, 16'h0200, 16'h0200, ZLI, 5'd17, 16'h0002, 0);
        exec("not_r0", mkir(18, 0, 2, 0), 0, 16'h0004, 16'h0004, ZLI, 5'd18, 16'h0000, 0);
        exec("sub_r0", mkir(4, 0, 15, 14), 0, 16'h8000, 16'h4000, ZLI, 5'd4, 16'h0000, 0);
        fetch("nop", mkir(26, 1, 1, 1), 0);
        step("nop_t3", 0, 0, 1, ev(0, 0, 0, 0, 1, 0));
        fetch("unk", mkir(20, 5, 5, 5), 0);
        step("unk_t3", 0, 0, 1, ev(0, 0, 0, 0, 1, 0));
        fetch("halt", mkir(27, 0, 0, 0), 0);
        step("halt_t3", 0, 1, 1, '0);
        for (int i = 0; i < 20; i++) step("halted", 0, 1, 1, ev(0, 0, 0, 0, 0, 1));
        step("halt_clr", 1, 1, 1, '0);
        step("halt_rst", 0, 1, 1, '0);
        fetch("after_halt", mkir(26, 0, 0, 0), 0);
        step("after_halt_t3", 0, 1, 1, ev(0, 0, 0, 0, 1, 0));
        fetch("clr_mid", 32'h42318000, 0);
        step("clr_mid_t3", 0, 0, 1, ev(0, 16'h0040, YI, 0, 0, 0));
        step("clr_mid_t4", 1, 0, 1, '0);
        step("clr_rst", 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step("t0_idle", 0, 0, 1, '0);
        fetch("resume", mkir(3, 5, 6, 7), 0);
        step("resume_t3", 0, 0, 1, ev(0, 16'h0040, YI, 0, 0, 0));
        step("resume_t4", 0, 0, 1, ev(0, 16'h0080, ZLI, 5'd3, 0, 0));
        step("resume_t5", 0, 0, 1, ev(16'h0020, 0, ZLO, 5'd3, 1, 0));
        step("back_t0_idle", 0, 0, 1, '0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
